// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM with memory-wait timeout.
// Define MC_CTRL_BNE_EN to decode bne (op 000101) as an inverted-zero branch.
module multicycle_controller #(
    parameter int ALUCTRL_W = 3,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic                 pcen,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 mem_timeout,
    output logic                 illegal_op
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic       w_wait_st;
    logic       w_timeout;
    logic [2:0] w_falu;
    logic       w_fok;

    logic       w_iord;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic       w_pcen;
    logic [2:0] w_alu;
    logic       w_to;
    logic       w_ill;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
    assign w_timeout = w_wait_st && !mem_ready &&
                       (r_cnt == CNT_W'(MAX_WAIT));

    // Only a stalled wait state keeps counting; every exit clears it.
    assign w_cnt_nxt = (w_wait_st && !mem_ready && !w_timeout) ?
                       r_cnt + CNT_W'(1) : '0;

    always_comb begin
        w_falu = ALU_AND;
        w_fok  = 1'b1;
        unique case (funct)
            6'b100000: w_falu = ALU_ADD;
            6'b100010: w_falu = ALU_SUB;
            6'b100100: w_falu = ALU_AND;
            6'b100101: w_falu = ALU_OR;
            6'b101010: w_falu = ALU_SLT;
            default:   w_fok  = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_iord      = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regdst    = 1'b0;
        w_memtoreg  = 1'b0;
        w_regwrite  = 1'b0;
        w_alusrca   = 1'b0;
        w_alusrcb   = 2'b00;
        w_pcsrc     = 2'b00;
        w_pcen      = 1'b0;
        w_alu       = ALU_AND;
        w_to        = 1'b0;
        w_ill       = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_alusrcb = 2'b01;
                w_alu     = ALU_ADD;
                if (w_timeout) begin
                    w_to        = 1'b1;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_irwrite = mem_ready;
                    w_pcen    = mem_ready;
                    if (mem_ready) w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                w_alu     = ALU_ADD;
                unique case (op)
                    OP_LW, OP_SW: w_state_nxt = S_MEMADR;
                    OP_R: begin
                        if (w_fok) begin
                            w_state_nxt = S_RTYPEEX;
                        end else begin
                            w_ill       = 1'b1;
                            w_state_nxt = S_FETCH;
                        end
                    end
                    OP_BEQ:  w_state_nxt = S_BEQEX;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:  w_state_nxt = S_BEQEX;
`endif
                    OP_ADDI: w_state_nxt = S_ADDIEX;
                    OP_J:    w_state_nxt = S_JEX;
                    default: begin
                        w_ill       = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_alu     = ALU_ADD;
                if (op == OP_SW) w_state_nxt = S_MEMWR;
                else if (op == OP_LW) w_state_nxt = S_MEMRD;
                else w_state_nxt = S_FETCH;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                if (w_timeout) begin
                    w_to        = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (mem_ready) begin
                    w_state_nxt = S_MEMWB;
                end
            end
            S_MEMWR: begin
                w_iord = 1'b1;
                if (w_timeout) begin
                    w_to        = 1'b1;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_memwrite = 1'b1;
                    if (mem_ready) w_state_nxt = S_FETCH;
                end
            end
            S_MEMWB: begin
                w_memtoreg  = 1'b1;
                w_regwrite  = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_RTYPEEX: begin
                w_alusrca   = 1'b1;
                w_alu       = w_falu;
                w_state_nxt = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                w_regdst    = 1'b1;
                w_regwrite  = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_BEQEX: begin
                w_alusrca   = 1'b1;
                w_alu       = ALU_SUB;
                w_pcsrc     = 2'b01;
                w_pcen      = zero;
`ifdef MC_CTRL_BNE_EN
                if (op == OP_BNE) w_pcen = ~zero;
`endif
                w_state_nxt = S_FETCH;
            end
            S_ADDIEX: begin
                w_alusrca   = 1'b1;
                w_alusrcb   = 2'b10;
                w_alu       = ALU_ADD;
                w_state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite  = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_JEX: begin
                w_pcsrc     = 2'b10;
                w_pcen      = 1'b1;
                w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Write strobes are gated by reset so they drop the instant it asserts.
    assign iord        = w_iord;
    assign memwrite    = w_memwrite & reset_n;
    assign irwrite     = w_irwrite & reset_n;
    assign regdst      = w_regdst;
    assign memtoreg    = w_memtoreg;
    assign regwrite    = w_regwrite & reset_n;
    assign alusrca     = w_alusrca;
    assign alusrcb     = w_alusrcb;
    assign pcsrc       = w_pcsrc;
    assign pcen        = w_pcen & reset_n;
    assign alucontrol  = ALUCTRL_W'(w_alu);
    assign mem_timeout = w_to & reset_n;
    assign illegal_op  = w_ill & reset_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller.
// Honours MC_CTRL_BNE_EN for the bne expectations.
module tb_multicycle_controller;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, pcen, mem_timeout, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int n_chk;
    int n_fail;

    multicycle_controller #(.ALUCTRL_W(3), .MAX_WAIT(15)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .op(op),
        .funct(funct),
        .zero(zero),
        .mem_ready(mem_ready),
        .iord(iord),
        .memwrite(memwrite),
        .irwrite(irwrite),
        .regdst(regdst),
        .memtoreg(memtoreg),
        .regwrite(regwrite),
        .alusrca(alusrca),
        .alusrcb(alusrcb),
        .pcsrc(pcsrc),
        .pcen(pcen),
        .alucontrol(alucontrol),
        .mem_timeout(mem_timeout),
        .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] w_outs;
    assign w_outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                     alusrca, alusrcb, pcsrc, pcen, alucontrol,
                     mem_timeout, illegal_op};

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    function automatic logic [16:0] mk(
        input logic io, mw, irw, rd, m2r, rw, asa,
        input logic [1:0] asb, pcs,
        input logic pe,
        input logic [2:0] alu,
        input logic to, il
    );
        return {io, mw, irw, rd, m2r, rw, asa, asb, pcs, pe, alu, to, il};
    endfunction

    logic [16:0] E_F, E_FW, E_FTO, E_DEC, E_DIL, E_MA, E_MR, E_MWB;
    logic [16:0] E_MW, E_MWTO, E_RSLT, E_RWB, E_BQ1, E_BQ0, E_AWB, E_J;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input logic r,
                       input logic [16:0] e);
        op        = o;
        funct     = f;
        zero      = z;
        mem_ready = r;
        #1;
        check(tag, 32'(w_outs), 32'(e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        E_F    = mk(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0,0);
        E_FW   = mk(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,0,0);
        E_FTO  = mk(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,1,0);
        E_DEC  = mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0,0);
        E_DIL  = mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0,1);
        E_MA   = mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0,0);
        E_MR   = mk(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b000,0,0);
        E_MWB  = mk(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b000,0,0);
        E_MW   = mk(1,1,0,0,0,0,0,2'b00,2'b00,0,3'b000,0,0);
        E_MWTO = mk(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b000,1,0);
        E_RSLT = mk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b111,0,0);
        E_RWB  = mk(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b000,0,0);
        E_BQ1  = mk(0,0,0,0,0,0,1,2'b00,2'b01,1,3'b110,0,0);
        E_BQ0  = mk(0,0,0,0,0,0,1,2'b00,2'b01,0,3'b110,0,0);
        E_AWB  = mk(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b000,0,0);
        E_J    = mk(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b000,0,0);

        reset_n   = 1'b0;
        op        = LW;
        funct     = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #2;
        check("reset_outs", 32'(w_outs), 32'(E_FW));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        cyc("lw_fetch",  LW, 6'd0, 0, 1, E_F);
        cyc("lw_decode", LW, 6'd0, 0, 1, E_DEC);
        cyc("lw_memadr", LW, 6'd0, 0, 1, E_MA);
        cyc("lw_memrd",  LW, 6'd0, 0, 1, E_MR);
        cyc("lw_memwb",  LW, 6'd0, 0, 1, E_MWB);

        cyc("slt_fetch", RT, 6'b101010, 0, 1, E_F);
        cyc("slt_dec",   RT, 6'b101010, 0, 1, E_DEC);
        cyc("slt_ex",    RT, 6'b101010, 0, 1, E_RSLT);
        cyc("slt_wb",    RT, 6'b101010, 0, 1, E_RWB);

        cyc("rbad_fetch", RT, 6'b000111, 0, 1, E_F);
        cyc("rbad_dec",   RT, 6'b000111, 0, 1, E_DIL);

        cyc("beq1_fetch", BEQ, 6'd0, 1, 1, E_F);
        cyc("beq1_dec",   BEQ, 6'd0, 1, 1, E_DEC);
        cyc("beq1_ex",    BEQ, 6'd0, 1, 1, E_BQ1);
        cyc("beq0_fetch", BEQ, 6'd0, 0, 1, E_F);
        cyc("beq0_dec",   BEQ, 6'd0, 0, 1, E_DEC);
        cyc("beq0_ex",    BEQ, 6'd0, 0, 1, E_BQ0);

        cyc("bne_fetch", BNE, 6'd0, 0, 1, E_F);
`ifdef MC_CTRL_BNE_EN
        cyc("bne_dec",   BNE, 6'd0, 0, 1, E_DEC);
        cyc("bne_ex",    BNE, 6'd0, 0, 1, E_BQ1);
`else
        cyc("bne_illegal", BNE, 6'd0, 0, 1, E_DIL);
`endif

        cyc("addi_fetch", ADDI, 6'd0, 0, 1, E_F);
        cyc("addi_dec",   ADDI, 6'd0, 0, 1, E_DEC);
        cyc("addi_ex",    ADDI, 6'd0, 0, 1, E_MA);
        cyc("addi_wb",    ADDI, 6'd0, 0, 1, E_AWB);

        cyc("j_fetch", JMP, 6'd0, 0, 1, E_F);
        cyc("j_dec",   JMP, 6'd0, 0, 1, E_DEC);
        cyc("j_ex",    JMP, 6'd0, 0, 1, E_J);

        cyc("badop_fetch", BAD, 6'd0, 0, 1, E_F);
        cyc("badop_dec",   BAD, 6'd0, 0, 1, E_DIL);

        cyc("sw_fetch",  SW, 6'd0, 0, 1, E_F);
        cyc("sw_dec",    SW, 6'd0, 0, 1, E_DEC);
        cyc("sw_memadr", SW, 6'd0, 0, 1, E_MA);
        for (int i = 0; i < 3; i++)
            cyc("sw_wait", SW, 6'd0, 0, 0, E_MW);
        cyc("sw_done", SW, 6'd0, 0, 1, E_MW);

        cyc("swto_fetch",  SW, 6'd0, 0, 1, E_F);
        cyc("swto_dec",    SW, 6'd0, 0, 1, E_DEC);
        cyc("swto_memadr", SW, 6'd0, 0, 1, E_MA);
        for (int i = 0; i < 15; i++)
            cyc("swto_wait", SW, 6'd0, 0, 0, E_MW);
        cyc("swto_pulse", SW, 6'd0, 0, 0, E_MWTO);

        for (int i = 0; i < 15; i++)
            cyc("fw_wait", JMP, 6'd0, 0, 0, E_FW);
        cyc("fw_ready_at_max", JMP, 6'd0, 0, 1, E_F);
        cyc("fw_dec", JMP, 6'd0, 0, 1, E_DEC);
        cyc("fw_jex", JMP, 6'd0, 0, 1, E_J);

        for (int i = 0; i < 15; i++)
            cyc("fto_wait", LW, 6'd0, 0, 0, E_FW);
        cyc("fto_pulse", LW, 6'd0, 0, 0, E_FTO);
        cyc("fto_after", LW, 6'd0, 0, 0, E_FW);

        cyc("rst_fetch",  LW, 6'd0, 0, 1, E_F);
        cyc("rst_dec",    LW, 6'd0, 0, 1, E_DEC);
        cyc("rst_memadr", LW, 6'd0, 0, 1, E_MA);
        cyc("rst_memrd",  LW, 6'd0, 0, 1, E_MR);
        #1;
        check("rst_memwb", 32'(w_outs), 32'(E_MWB));
        reset_n = 1'b0;
        #1;
        check("rst_async_regwrite", 32'(regwrite), 32'd0);
        check("rst_async_outs", 32'(w_outs), 32'(E_FW));
        @(posedge clk);
        #1;
        check("rst_held", 32'(w_outs), 32'(E_FW));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc("post_rst_fetch", LW, 6'd0, 0, 1, E_F);
        cyc("post_rst_dec",   LW, 6'd0, 0, 1, E_DEC);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
